// File: rtl/bleeptrack_prism.sv
// Generative "prism" picture for a 640x480@60 VGA TinyTapeout tile: a white beam
// enters a triangular prism and leaves as a six-band rainbow that can scroll.
module bleeptrack_prism (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [9:0] h_count;
  logic [9:0] v_count;
  logic [2:0] frame_count;
  logic [2:0] phase;

  logic        line_end;
  logic        frame_end;
  logic        h_sync;
  logic        v_sync;
  logic        visible;
  logic        prism_rows;
  logic [9:0]  v_off;
  logic [9:0]  half_width;
  logic [10:0] h_diff;
  logic [10:0] h_abs;
  logic        prism_hit;
  logic        prism_edge;
  logic        beam_hit;
  logic        rainbow_hit;
  logic [9:0]  v_band;
  logic [3:0]  band_sum;
  logic [3:0]  band;
  logic [1:0]  red;
  logic [1:0]  green;
  logic [1:0]  blue;
  logic [7:0]  pixel;
  logic        unused_ok;

  assign uio_out   = 8'h00;
  assign uio_oe    = 8'h00;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:1]};

  assign line_end  = (h_count == 10'd799);
  assign frame_end = line_end && (v_count == 10'd524);

  assign h_sync  = !((h_count >= 10'd656) && (h_count < 10'd752));
  assign v_sync  = !((v_count >= 10'd490) && (v_count < 10'd492));
  assign visible = (h_count < 10'd640) && (v_count < 10'd480);

  // Prism half-width grows by one pixel every two lines below its apex at row 140.
  assign prism_rows = (v_count >= 10'd140) && (v_count < 10'd340);
  assign v_off      = v_count - 10'd140;
  assign half_width = v_off >> 1;
  assign h_diff     = {1'b0, h_count} - 11'd320;
  assign h_abs      = h_diff[10] ? (11'd0 - h_diff) : h_diff;

  // Edge test is written as d+1 >= hw so the apex rows (hw==0) count as outline.
  assign prism_hit  = prism_rows && (h_abs <= {1'b0, half_width});
  assign prism_edge = ((h_abs + 11'd1) >= {1'b0, half_width}) || (v_count >= 10'd338);

  assign beam_hit    = prism_rows && (v_count >= 10'd236) && (v_count < 10'd244)
                       && (h_count < (10'd320 - half_width));
  assign rainbow_hit = (h_count >= 10'd384) && (v_count >= 10'd192) && (v_count < 10'd288);

  assign v_band   = v_count - 10'd192;
  assign band_sum = 4'(v_band >> 4) + {1'b0, phase};
  assign band     = (band_sum >= 4'd6) ? (band_sum - 4'd6) : band_sum;

  always_comb begin
    red   = 2'd0;
    green = 2'd0;
    blue  = 2'd0;
    if (visible) begin
      if (prism_hit) begin
        if (prism_edge) begin
          red   = 2'd3;
          green = 2'd3;
          blue  = 2'd3;
        end else begin
          red   = 2'd1;
          green = 2'd1;
          blue  = 2'd1;
        end
      end else if (beam_hit) begin
        red   = 2'd3;
        green = 2'd3;
        blue  = 2'd3;
      end else if (rainbow_hit) begin
        case (band)
          4'd0:    red = 2'd3;
          4'd1:    begin red = 2'd3; green = 2'd1; end
          4'd2:    begin red = 2'd3; green = 2'd3; end
          4'd3:    green = 2'd3;
          4'd4:    blue = 2'd3;
          4'd5:    begin red = 2'd2; blue = 2'd3; end
          default: red = 2'd0;
        endcase
      end
    end
  end

  assign pixel = {h_sync, blue[0], green[0], red[0], v_sync, blue[1], green[1], red[1]};

  // Phase steps once every eight frames while animation is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count     <= 10'd0;
      v_count     <= 10'd0;
      frame_count <= 3'd0;
      phase       <= 3'd0;
      uo_out      <= 8'h88;
    end else begin
      h_count <= line_end ? 10'd0 : h_count + 10'd1;
      if (line_end) begin
        v_count <= (v_count == 10'd524) ? 10'd0 : v_count + 10'd1;
      end
      if (frame_end) begin
        frame_count <= frame_count + 3'd1;
        if (ui_in[0] && (frame_count == 3'd7)) begin
          phase <= (phase == 3'd5) ? 3'd0 : phase + 3'd1;
        end
      end
      uo_out <= pixel;
    end
  end

endmodule

// File: tb/tb_bleeptrack_prism.sv
// Scoreboard bench for bleeptrack_prism: a reference pixel model predicts every output
// byte; rows are pinned via force on the line counter to reach the picture quickly.
module tb_bleeptrack_prism;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int failures = 0;

  int mh, mv, mfc, mp;
  bit vHeld = 1'b0;
  int vHoldVal;
  logic [9:0] heldRow;
  logic [7:0] expQ[$];

  bit spotOn = 1'b0;
  int spotH, spotV;
  logic [7:0] spotVal;

  int lowCount, firstFall, secondFall;
  logic prevHs;
  int rows[18] = '{141, 160, 200, 236, 240, 243, 250, 280, 288,
                   300, 338, 339, 340, 479, 480, 490, 491, 492};
  logic [7:0] bandColour[6] = '{8'h99, 8'hB9, 8'hBB, 8'hAA, 8'hCC, 8'hCD};

  bleeptrack_prism dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #20 clk = ~clk;

  function automatic logic [7:0] modelPixel(int h, int v, int p);
    int r = 0, g = 0, b = 0, hw = 0, d, band;
    bit hs, vs;
    hs = !(h >= 656 && h < 752);
    vs = !(v >= 490 && v < 492);
    if (h < 640 && v < 480) begin
      if (v >= 140 && v < 340) hw = (v - 140) / 2;
      d = (h >= 320) ? h - 320 : 320 - h;
      if (v >= 140 && v < 340 && d <= hw) begin
        if (d >= hw - 1 || v >= 338) begin r = 3; g = 3; b = 3; end
        else begin r = 1; g = 1; b = 1; end
      end else if (v >= 236 && v < 244 && h < 320 - hw) begin
        r = 3; g = 3; b = 3;
      end else if (h >= 384 && v >= 192 && v < 288) begin
        band = ((v - 192) / 16 + p) % 6;
        case (band)
          0: r = 3;
          1: begin r = 3; g = 1; end
          2: begin r = 3; g = 3; end
          3: g = 3;
          4: b = 3;
          default: begin r = 2; b = 3; end
        endcase
      end
    end
    return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (model h=%0d v=%0d p=%0d)",
               tag, observed, expected, mh, mv, mp);
    end
  endtask

  // One clock: push the prediction for the pre-edge state, advance the model, compare.
  task automatic stepCycle(input string tag);
    logic [7:0] e;
    bit spotHit;
    e = rst_n ? modelPixel(mh, mv, mp) : 8'h88;
    spotHit = spotOn && rst_n && (mh == spotH) && (mv == spotV);
    expQ.push_back(e);
    @(posedge clk);
    if (rst_n) begin
      if (mh == 799) begin
        mh = 0;
        if (mv == 524) begin
          if (ui_in[0] && mfc == 7) mp = (mp == 5) ? 0 : mp + 1;
          mfc = (mfc + 1) % 8;
          mv = 0;
        end else begin
          mv++;
        end
      end else begin
        mh++;
      end
      if (vHeld) mv = vHoldVal;
    end
    #1;
    checkOutput(tag, uo_out, expQ.pop_front());
    if (spotHit) checkOutput("spot_pixel", uo_out, spotVal);
    ena = 1'($urandom_range(0, 1));
    uio_in = 8'($urandom);
  endtask

  task automatic applyStimulus(input logic [7:0] ui, input int cycles, input string tag);
    ui_in = ui;
    repeat (cycles) stepCycle(tag);
  endtask

  task automatic resetDut(input int n);
    rst_n = 1'b0;
    if (vHeld) begin
      release dut.v_count;
      vHeld = 1'b0;
    end
    mh = 0; mv = 0; mfc = 0; mp = 0;
    expQ.delete();
    #1;
    checkOutput("reset_async", uo_out, 8'h88);
    repeat (n) stepCycle("reset_hold");
    checkOutput("uio_out", uio_out, 8'h00);
    checkOutput("uio_oe", uio_oe, 8'h00);
    rst_n = 1'b1;
  endtask

  task automatic holdRow(input int row);
    heldRow = 10'(row);
    force dut.v_count = heldRow;
    vHeld = 1'b1;
    vHoldVal = row;
    mv = row;
  endtask

  task automatic setSpot(input int h, input int v, input logic [7:0] val);
    spotOn = 1'b1;
    spotH = h;
    spotV = v;
    spotVal = val;
  endtask

  initial begin
    #5;
    resetDut(10);

    // Line timing straight out of reset.
    lowCount = 0; firstFall = -1; secondFall = -1; prevHs = 1'b1;
    for (int k = 1; k <= 1700; k++) begin
      stepCycle("scan_top");
      if (!uo_out[7] && k <= 800) lowCount++;
      if (prevHs && !uo_out[7]) begin
        if (firstFall < 0) firstFall = k;
        else if (secondFall < 0) secondFall = k;
      end
      prevHs = uo_out[7];
    end
    checkOutput("hsync_low_len", lowCount, 96);
    checkOutput("hsync_first_fall", firstFall, 657);
    checkOutput("hsync_period", secondFall - firstFall, 800);

    // Mid-frame reset, then the scan must restart from the origin.
    resetDut(3);
    applyStimulus(8'h00, 900, "scan_restart");

    // Static picture rows.
    foreach (rows[i]) begin
      holdRow(rows[i]);
      case (rows[i])
        141: setSpot(320, 141, 8'hFF);
        200: setSpot(500, 200, 8'h99);
        240: setSpot(100, 240, 8'hFF);
        250: setSpot(320, 250, 8'hF8);
        280: setSpot(500, 280, 8'hCD);
        300: setSpot(500, 300, 8'h88);
        default: spotOn = 1'b0;
      endcase
      applyStimulus(8'h00, 800, "row_scan");
      spotOn = 1'b0;
    end

    // Animation: each line pinned at row 524 is one end of frame.
    resetDut(2);
    for (int f = 1; f <= 48; f++) begin
      holdRow(524);
      applyStimulus(8'h01, 800, "frame_end_line");
      if (f % 8 == 0) begin
        holdRow(200);
        setSpot(500, 200, bandColour[(f / 8) % 6]);
        applyStimulus(8'h01, 800, "anim_row");
        spotOn = 1'b0;
      end
    end

    // Animation disabled: the band colour must stay frozen.
    for (int f = 1; f <= 8; f++) begin
      holdRow(524);
      applyStimulus(8'h00, 800, "frozen_frame_line");
    end
    holdRow(200);
    setSpot(500, 200, 8'h99);
    applyStimulus(8'h00, 800, "frozen_row");
    spotOn = 1'b0;

    resetDut(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
